score_round_ctrl: RTL and testbench
===================================

SCORE_ROUND_CTRL -- requirements
Module: score_round_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clk cycles per one-second tick.
REQ-002 SHALL have parameter ROUND_SECS, default 30, round length in seconds (1..127).
REQ-003 SHALL have parameter INIT_HOLD, default 40, cycles after reset before the first score_req may issue (covers downstream 32-cycle RAM clear).
REQ-004 SHALL have parameter VALID_TIMEOUT, default 64, max cycles waited for valid.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  request to begin a round (level, sampled each cycle).
REQ-008 hit  in  1  scoring input (debounced level); each 0->1 edge is one point.
REQ-009 logged_in  in  1  player session active.
REQ-010 login_id  in  3  current player ID.
REQ-011 login_guest  in  1  current player is a guest.
REQ-012 valid  in  1  downstream score tracker finished processing.
REQ-013 personal_winner, global_winner  in  1 each  downstream results, meaningful when valid=1.
REQ-014 score_req  out  1  one-cycle request to score tracker.
REQ-015 score  out  7  final round score, held stable from score_req until next round start.
REQ-016 playerID  out  3  player ID latched at round start.
REQ-017 isGuest  out  1  guest flag latched at round start.
REQ-018 round_active  out  1  high during PLAY.
REQ-019 time_left  out  7  seconds remaining in round.
REQ-020 result_pw, result_gw  out  1 each  latched downstream results.
REQ-021 result_ok  out  1  high in SHOW when results valid; err  out  1  high in SHOW after timeout/abort.

Function
REQ-022 SHALL implement states IDLE, PLAY, REQ, WAIT_VALID, SHOW.
REQ-023 SHALL count init_cnt from 0 up to INIT_HOLD after reset and hold there; ready = (init_cnt==INIT_HOLD).
REQ-024 IDLE/SHOW -> PLAY when start=1 and logged_in=1; same edge latches playerID<=login_id, isGuest<=login_guest, clears score, prescaler, result_*, err, loads time_left<=ROUND_SECS.
REQ-025 In PLAY, prescaler counts 0..TICK_DIV-1; on wrap, time_left decrements; PLAY lasts exactly ROUND_SECS*TICK_DIV cycles.
REQ-026 In PLAY, each hit 0->1 edge (hit=1, previous-cycle hit=0) increments score, saturating at 127; hit edge detector SHALL reset to previous=1 on round start so a held button scores nothing.
REQ-027 A hit edge on the final PLAY cycle SHALL count.
REQ-028 start while in PLAY, REQ or WAIT_VALID SHALL be ignored.
REQ-029 logged_in=0 during PLAY SHALL abort: -> SHOW with err=1, no score_req.
REQ-030 When time_left reaches 0, -> REQ; REQ holds until ready=1, then drives score_req=1 for exactly one cycle and -> WAIT_VALID.
REQ-031 WAIT_VALID: on valid=1 latch result_pw<=personal_winner, result_gw<=global_winner, result_ok<=1, -> SHOW.
REQ-032 WAIT_VALID: if valid not seen within VALID_TIMEOUT cycles after score_req, -> SHOW with err=1, result_*=0.
REQ-033 valid outside WAIT_VALID SHALL be ignored.
REQ-034 SHOW holds results until next accepted start, or logged_in=0 (-> IDLE, results cleared).
REQ-035 score_req SHALL never assert more than once per round.

Reset
REQ-036 rst=1 SHALL force, on the next edge: state IDLE, score_req=0, score=0, playerID=0, isGuest=0, round_active=0, time_left=0, result_pw=0, result_gw=0, result_ok=0, err=0, init_cnt=0, prescaler=0.
REQ-037 rst mid-round SHALL discard the round with no score_req.

Verification (TICK_DIV=4, ROUND_SECS=3, INIT_HOLD=40, VALID_TIMEOUT=64)
REQ-038 start at cycle 50, 5 hit pulses in PLAY -> round_active high 12 cycles, score_req one cycle, score=5; valid after 7 cycles with pw=1, gw=0 -> SHOW, result_pw=1, result_gw=0, result_ok=1.
REQ-039 hit held high across start -> score=0; 130 hit edges (TICK_DIV raised) -> score=127.
REQ-040 start at cycle 2 after reset with 0 hits -> score_req delayed until cycle ≥40, single pulse.
REQ-041 valid never returned -> err=1, result_ok=0 exactly 64 cycles after score_req.
REQ-042 logged_in dropped mid-PLAY -> SHOW, err=1, no score_req; start during PLAY -> time_left unaffected.
REQ-043 rst asserted in WAIT_VALID, then valid=1 -> all outputs zero, state IDLE, valid ignored.

Source files
------------

// File: rtl/score_round_ctrl.sv
// Round controller: timed PLAY window, single score_req to the score tracker, result latch.
// score_req is decoded from registered state the cycle ready is seen; all other outputs are registered.
module score_round_ctrl #(
    parameter int TICK_DIV      = 50000000,
    parameter int ROUND_SECS    = 30,
    parameter int INIT_HOLD     = 40,
    parameter int VALID_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       logged_in,
    input  logic [2:0] login_id,
    input  logic       login_guest,
    input  logic       valid,
    input  logic       personal_winner,
    input  logic       global_winner,
    output logic       score_req,
    output logic [6:0] score,
    output logic [2:0] playerID,
    output logic       isGuest,
    output logic       round_active,
    output logic [6:0] time_left,
    output logic       result_pw,
    output logic       result_gw,
    output logic       result_ok,
    output logic       err
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (INIT_HOLD > 0) ? $clog2(INIT_HOLD + 1) : 1;
    localparam int VW = $clog2(VALID_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, PLAY, REQ, WAIT_VALID, SHOW} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] init_cnt_q, init_cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    time_q, time_d;
    logic [6:0]    score_q, score_d;
    logic [2:0]    id_q, id_d;
    logic          guest_q, guest_d;
    logic          hit_prev_q, hit_prev_d;
    logic [VW-1:0] wait_q, wait_d;
    logic          pw_q, pw_d, gw_q, gw_d, ok_q, ok_d, err_q, err_d;
    logic          ready;
    logic          req_now;

    assign ready = (init_cnt_q == IW'(INIT_HOLD));

    always_comb begin
        state_d    = state_q;
        init_cnt_d = ready ? init_cnt_q : init_cnt_q + 1'b1;
        presc_d    = presc_q;
        time_d     = time_q;
        score_d    = score_q;
        id_d       = id_q;
        guest_d    = guest_q;
        hit_prev_d = hit;
        wait_d     = wait_q;
        pw_d       = pw_q;
        gw_d       = gw_q;
        ok_d       = ok_q;
        err_d      = err_q;
        req_now    = 1'b0;

        case (state_q)
            IDLE, SHOW: begin
                if (start && logged_in) begin
                    state_d    = PLAY;
                    id_d       = login_id;
                    guest_d    = login_guest;
                    score_d    = 7'd0;
                    presc_d    = '0;
                    time_d     = 7'(ROUND_SECS);
                    // A button already held at start must not score.
                    hit_prev_d = 1'b1;
                    pw_d       = 1'b0;
                    gw_d       = 1'b0;
                    ok_d       = 1'b0;
                    err_d      = 1'b0;
                end else if (!logged_in) begin
                    state_d = IDLE;
                    pw_d    = 1'b0;
                    gw_d    = 1'b0;
                    ok_d    = 1'b0;
                    err_d   = 1'b0;
                end
            end
            PLAY: begin
                if (!logged_in) begin
                    state_d = SHOW;
                    err_d   = 1'b1;
                end else begin
                    if (hit && !hit_prev_q && score_q != 7'd127) begin
                        score_d = score_q + 7'd1;
                    end
                    if (presc_q == PW'(TICK_DIV - 1)) begin
                        presc_d = '0;
                        time_d  = time_q - 7'd1;
                        if (time_q == 7'd1) begin
                            state_d = REQ;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            REQ: begin
                if (ready) begin
                    req_now = 1'b1;
                    wait_d  = VW'(1);
                    state_d = WAIT_VALID;
                end
            end
            WAIT_VALID: begin
                if (valid) begin
                    pw_d    = personal_winner;
                    gw_d    = global_winner;
                    ok_d    = 1'b1;
                    state_d = SHOW;
                end else if (wait_q == VW'(VALID_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = SHOW;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            init_cnt_q <= '0;
            presc_q    <= '0;
            time_q     <= 7'd0;
            score_q    <= 7'd0;
            id_q       <= 3'd0;
            guest_q    <= 1'b0;
            hit_prev_q <= 1'b1;
            wait_q     <= '0;
            pw_q       <= 1'b0;
            gw_q       <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            presc_q    <= presc_d;
            time_q     <= time_d;
            score_q    <= score_d;
            id_q       <= id_d;
            guest_q    <= guest_d;
            hit_prev_q <= hit_prev_d;
            wait_q     <= wait_d;
            pw_q       <= pw_d;
            gw_q       <= gw_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    assign score_req    = req_now;
    assign score        = score_q;
    assign playerID     = id_q;
    assign isGuest      = guest_q;
    assign round_active = (state_q == PLAY);
    assign time_left    = time_q;
    assign result_pw    = pw_q;
    assign result_gw    = gw_q;
    assign result_ok    = ok_q;
    assign err          = err_q;
endmodule

// File: tb/tb_score_round_ctrl.sv
// Directed bench for score_round_ctrl with a small scoreboard of expected requests and results.
module tb_score_round_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, hit, logged_in, login_guest, valid, personal_winner, global_winner;
    logic [2:0] login_id;
    logic       score_req, isGuest, round_active, result_pw, result_gw, result_ok, err;
    logic [6:0] score, time_left;
    logic [2:0] playerID;
    logic       start2, hit2, score_req2, isGuest2, round_active2, result_pw2, result_gw2, result_ok2, err2;
    logic [6:0] score2, time_left2;
    logic [2:0] playerID2;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {logic [6:0] score; logic [2:0] id; logic guest;} req_exp_t;
    typedef struct packed {logic pw; logic gw; logic ok; logic err;} res_exp_t;
    req_exp_t req_sb[$];
    res_exp_t res_sb[$];

    score_round_ctrl #(.TICK_DIV(4), .ROUND_SECS(3), .INIT_HOLD(40), .VALID_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .start(start), .hit(hit), .logged_in(logged_in),
        .login_id(login_id), .login_guest(login_guest), .valid(valid),
        .personal_winner(personal_winner), .global_winner(global_winner),
        .score_req(score_req), .score(score), .playerID(playerID), .isGuest(isGuest),
        .round_active(round_active), .time_left(time_left), .result_pw(result_pw),
        .result_gw(result_gw), .result_ok(result_ok), .err(err)
    );

    score_round_ctrl #(.TICK_DIV(100), .ROUND_SECS(3), .INIT_HOLD(40), .VALID_TIMEOUT(64)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .hit(hit2), .logged_in(logged_in),
        .login_id(login_id), .login_guest(login_guest), .valid(valid),
        .personal_winner(personal_winner), .global_winner(global_winner),
        .score_req(score_req2), .score(score2), .playerID(playerID2), .isGuest(isGuest2),
        .round_active(round_active2), .time_left(time_left2), .result_pw(result_pw2),
        .result_gw(result_gw2), .result_ok(result_ok2), .err(err2)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_round(input logic [2:0] id, input logic g);
        start       = 1'b1;
        login_id    = id;
        login_guest = g;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_req(input int budget, output int waited);
        req_exp_t e;
        waited = 0;
        while (score_req !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
        chk("score_req_seen", 32'(score_req), 32'd1);
        chk("req_sb_nonempty", 32'(req_sb.size() > 0), 32'd1);
        if (req_sb.size() > 0) begin
            e = req_sb.pop_front();
            chk("req_score", 32'(score), 32'(e.score));
            chk("req_playerID", 32'(playerID), 32'(e.id));
            chk("req_isGuest", 32'(isGuest), 32'(e.guest));
        end
        tick();
        chk("score_req_single", 32'(score_req), 32'd0);
    endtask

    task automatic check_res();
        res_exp_t e;
        chk("res_sb_nonempty", 32'(res_sb.size() > 0), 32'd1);
        if (res_sb.size() > 0) begin
            e = res_sb.pop_front();
            chk("result_pw", 32'(result_pw), 32'(e.pw));
            chk("result_gw", 32'(result_gw), 32'(e.gw));
            chk("result_ok", 32'(result_ok), 32'(e.ok));
            chk("err", 32'(err), 32'(e.err));
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited, act, elapsed, nreq;
        rst = 1'b1; start = 1'b0; hit = 1'b0; logged_in = 1'b1; login_id = 3'd0;
        login_guest = 1'b0; valid = 1'b0; personal_winner = 1'b0; global_winner = 1'b0;
        start2 = 1'b0; hit2 = 1'b0;
        repeat (2) tick();
        chk("rst_score_req", 32'(score_req), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_playerID", 32'(playerID), 32'd0);
        chk("rst_isGuest", 32'(isGuest), 32'd0);
        chk("rst_round_active", 32'(round_active), 32'd0);
        chk("rst_time_left", 32'(time_left), 32'd0);
        chk("rst_result_pw", 32'(result_pw), 32'd0);
        chk("rst_result_gw", 32'(result_gw), 32'd0);
        chk("rst_result_ok", 32'(result_ok), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Early start: request must wait for the init hold.
        rst = 1'b0;
        tick();
        start_round(3'd5, 1'b1);
        req_sb.push_back('{score: 7'd0, id: 3'd5, guest: 1'b1});
        chk("early_round_active", 32'(round_active), 32'd1);
        wait_req(100, waited);
        chk("req_after_hold", 32'(2 + waited >= 40), 32'd1);
        valid = 1'b1; personal_winner = 1'b0; global_winner = 1'b1;
        res_sb.push_back('{pw: 1'b0, gw: 1'b1, ok: 1'b1, err: 1'b0});
        tick();
        valid = 1'b0; global_winner = 1'b0;
        check_res();

        // Nominal round: 5 hits, last on the final PLAY cycle.
        start_round(3'd2, 1'b0);
        req_sb.push_back('{score: 7'd5, id: 3'd2, guest: 1'b0});
        chk("play_time_left", 32'(time_left), 32'd3);
        act = 0;
        for (int i = 0; i < 40 && round_active === 1'b1; i++) begin
            act++;
            hit = (i == 1 || i == 3 || i == 5 || i == 7 || i == 11);
            tick();
        end
        hit = 1'b0;
        chk("round_active_cycles", 32'(act), 32'd12);
        wait_req(5, waited);
        repeat (6) tick();
        chk("ok_before_valid", 32'(result_ok), 32'd0);
        valid = 1'b1; personal_winner = 1'b1; global_winner = 1'b0;
        res_sb.push_back('{pw: 1'b1, gw: 1'b0, ok: 1'b1, err: 1'b0});
        tick();
        valid = 1'b0; personal_winner = 1'b0;
        check_res();
        chk("show_score", 32'(score), 32'd5);
        chk("show_round_active", 32'(round_active), 32'd0);

        // Start ignored during PLAY, then logout abort.
        start_round(3'd3, 1'b0);
        start = 1'b1;
        repeat (6) tick();
        chk("restart_ignored_time_left", 32'(time_left), 32'd2);
        chk("restart_ignored_active", 32'(round_active), 32'd1);
        start = 1'b0;
        logged_in = 1'b0;
        res_sb.push_back('{pw: 1'b0, gw: 1'b0, ok: 1'b0, err: 1'b1});
        tick();
        check_res();
        chk("abort_round_active", 32'(round_active), 32'd0);
        tick();
        chk("logout_clears_err", 32'(err), 32'd0);
        logged_in = 1'b1;
        nreq = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                valid = 1'b1; personal_winner = 1'b1;
            end else begin
                valid = 1'b0; personal_winner = 1'b0;
            end
            tick();
            nreq += int'(score_req);
        end
        chk("abort_no_req", 32'(nreq), 32'd0);
        chk("idle_valid_ignored_ok", 32'(result_ok), 32'd0);
        chk("idle_valid_ignored_pw", 32'(result_pw), 32'd0);

        // Held hit scores nothing; no valid -> timeout.
        hit = 1'b1;
        start_round(3'd6, 1'b1);
        req_sb.push_back('{score: 7'd0, id: 3'd6, guest: 1'b1});
        res_sb.push_back('{pw: 1'b0, gw: 1'b0, ok: 1'b0, err: 1'b1});
        wait_req(40, waited);
        elapsed = 1;
        while (err !== 1'b1 && elapsed < 100) begin
            tick();
            elapsed++;
        end
        chk("timeout_cycles", 32'(elapsed), 32'd64);
        check_res();
        hit = 1'b0;

        // Reset mid-PLAY discards the round.
        start_round(3'd1, 1'b0);
        hit = 1'b1; tick(); hit = 1'b0; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midplay_rst_active", 32'(round_active), 32'd0);
        chk("midplay_rst_score", 32'(score), 32'd0);
        nreq = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            nreq += int'(score_req);
        end
        chk("midplay_rst_no_req", 32'(nreq), 32'd0);

        // Reset in WAIT_VALID; valid afterwards is ignored.
        start_round(3'd4, 1'b1);
        tick();
        hit = 1'b1; tick(); hit = 1'b0; tick(); hit = 1'b1; tick(); hit = 1'b0;
        req_sb.push_back('{score: 7'd2, id: 3'd4, guest: 1'b1});
        wait_req(40, waited);
        rst = 1'b1; tick(); rst = 1'b0;
        valid = 1'b1; personal_winner = 1'b1; global_winner = 1'b1;
        repeat (2) tick();
        valid = 1'b0; personal_winner = 1'b0; global_winner = 1'b0;
        chk("wv_rst_score_req", 32'(score_req), 32'd0);
        chk("wv_rst_score", 32'(score), 32'd0);
        chk("wv_rst_playerID", 32'(playerID), 32'd0);
        chk("wv_rst_isGuest", 32'(isGuest), 32'd0);
        chk("wv_rst_round_active", 32'(round_active), 32'd0);
        chk("wv_rst_time_left", 32'(time_left), 32'd0);
        chk("wv_rst_result_pw", 32'(result_pw), 32'd0);
        chk("wv_rst_result_gw", 32'(result_gw), 32'd0);
        chk("wv_rst_result_ok", 32'(result_ok), 32'd0);
        chk("wv_rst_err", 32'(err), 32'd0);

        // Saturation on the long-tick instance: 130 edges -> 127.
        login_id = 3'd7; login_guest = 1'b0;
        start2 = 1'b1; tick(); start2 = 1'b0;
        tick();
        for (int i = 0; i < 130; i++) begin
            hit2 = 1'b1; tick();
            hit2 = 1'b0; tick();
            if (i == 9) chk("sat_partial_score", 32'(score2), 32'd10);
        end
        chk("sat_still_active", 32'(round_active2), 32'd1);
        waited = 0;
        while (score_req2 !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        chk("sat_score_req", 32'(score_req2), 32'd1);
        chk("sat_score", 32'(score2), 32'd127);
        chk("sat_playerID", 32'(playerID2), 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
